// File: rtl/cia_pkg.sv
// Shared definitions for the CIA-style timer bank: register offsets inside a
// channel window, control-register bit positions, ICR set/clear bit, the
// control-register storage type and small address/size helpers.
// No ports (package).
package cia_pkg;

  // Each timer channel owns an 8-byte register window.
  localparam int REGS_PER_CH = 8;

  // Offsets inside a channel window.
  localparam int CNT0_OFF = 0;
  localparam int CR_OFF   = 4;

  // Control register bit positions.
  localparam int CR_START   = 0;
  localparam int CR_RUNMODE = 3;
  localparam int CR_LOAD    = 4;
  localparam int CR_INMODE  = 5;

  // ICR write: bit 7 selects set (1) or clear (0) of the mask bits.
  localparam int ICR_SETCLR = 7;

  // Stored control bits; LOAD is a strobe and is never stored.
  typedef struct packed {
    logic inmode;
    logic runmode;
    logic start;
  } cr_t;

  // Bytes per counter.
  function automatic int nb_of(input int tw);
    return tw / 8;
  endfunction

  // ICR sits directly after the last channel window.
  function automatic int icr_addr(input int ntmr);
    return REGS_PER_CH * ntmr;
  endfunction

endpackage

// File: rtl/cia_timer_bank_if.sv
// CIA-style 8-bit register bus bundle.
//   aen      address enable
//   rd, wr   read / write strobes
//   rs       register select (AW bits)
//   data_in  write data
//   data_out read data (0 when not selected or not reading)
// master: the bus driver (CPU side); slave: the timer bank.
interface cia_timer_bank_if #(
  parameter int AW = 6
);
  logic          aen;
  logic          rd;
  logic          wr;
  logic [AW-1:0] rs;
  logic [7:0]    data_in;
  logic [7:0]    data_out;

  modport master (
    output aen, rd, wr, rs, data_in,
    input  data_out
  );

  modport slave (
    input  aen, rd, wr, rs, data_in,
    output data_out
  );
endinterface

// File: rtl/cia_tmr_chan.sv
// One timer channel: reload latch, down-counter, control register and the
// high-byte read snapshot used for tear-free multi-byte reads.
// Ports:
//   clk, reset_n, clk7_en  clock, sync active-low reset, state-advance enable
//   cnt_in                 count source already selected by the parent
//                          (eclk or predecessor underflow)
//   wsel, rsel             write / read of this channel's window this cycle
//   off                    offset inside the 8-byte window
//   data_in                write data
//   rdata                  read data, 0 unless rsel
//   inmode                 current INMODE bit, for the parent's source mux
//   ovf                    underflow this cycle (combinational, gated by
//                          clk7_en and reset so it can ripple into successors)
module cia_tmr_chan
  import cia_pkg::*;
#(
  parameter int TW = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clk7_en,
  input  logic       cnt_in,
  input  logic       wsel,
  input  logic       rsel,
  input  logic [2:0] off,
  input  logic [7:0] data_in,
  output logic [7:0] rdata,
  output logic       inmode,
  output logic       ovf
);

  localparam int NB = nb_of(TW);

  logic [TW-1:0] latch;
  logic [TW-1:0] latch_nx;
  logic [TW-1:0] counter;
  cr_t           cr;
  logic          cr_wr;
  logic          load_cr;
  logic          top_wr;
  logic          cnt_evt;
  logic          at_zero;
  logic [7:0]    snap_byte;
  logic [7:0]    cr_byte;

  // Latch with this cycle's byte write merged in, so a top-byte write can
  // load the counter with the complete new value in the same cycle.
  always_comb begin
    latch_nx = latch;
    for (int b = 0; b < NB; b++) begin
      if (wsel && off == 3'(b)) latch_nx[8*b +: 8] = data_in;
    end
  end

  assign cr_wr   = wsel & (off == 3'(CR_OFF));
  assign load_cr = cr_wr & data_in[CR_LOAD];
  assign top_wr  = wsel & (off == 3'(NB-1));
  assign cnt_evt = cr.start & cnt_in;
  assign at_zero = (counter == '0);
  assign inmode  = cr.inmode;

  // A forced load suppresses the count for that cycle, including underflow.
  assign ovf = reset_n & clk7_en & cnt_evt & at_zero & ~load_cr;

  always_ff @(posedge clk) begin
    if (clk7_en) begin
      if (!reset_n) begin
        latch   <= '1;
        counter <= '1;
        cr      <= '0;
      end else begin
        latch <= latch_nx;

        if (load_cr || (top_wr && !cr.start)) begin
          counter <= latch_nx;
        end else if (cnt_evt) begin
          counter <= at_zero ? latch_nx : counter - TW'(1);
        end

        // An explicit CR write beats load-and-go, which beats one-shot stop.
        if (cr_wr) begin
          cr.start   <= data_in[CR_START];
          cr.runmode <= data_in[CR_RUNMODE];
          cr.inmode  <= data_in[CR_INMODE];
        end else if (top_wr && cr.runmode) begin
          cr.start <= 1'b1;
        end else if (ovf && cr.runmode) begin
          cr.start <= 1'b0;
        end
      end
    end
  end

  // Reading byte 0 freezes the upper bytes so a following multi-byte read
  // sees one consistent counter value.
  if (NB > 1) begin : g_snap
    logic [TW-9:0] snap;

    always_ff @(posedge clk) begin
      if (clk7_en) begin
        if (!reset_n) begin
          snap <= '0;
        end else if (rsel && off == 3'(CNT0_OFF)) begin
          snap <= counter[TW-1:8];
        end
      end
    end

    always_comb begin
      snap_byte = '0;
      for (int b = 1; b < NB; b++) begin
        if (off == 3'(b)) snap_byte = snap[8*(b-1) +: 8];
      end
    end
  end else begin : g_nosnap
    assign snap_byte = '0;
  end

  always_comb begin
    cr_byte             = '0;
    cr_byte[CR_START]   = cr.start;
    cr_byte[CR_RUNMODE] = cr.runmode;
    cr_byte[CR_INMODE]  = cr.inmode;
  end

  // snap_byte is already 0 for reserved offsets.
  always_comb begin
    rdata = '0;
    if (rsel) begin
      if (off == 3'(CNT0_OFF))    rdata = counter[7:0];
      else if (off == 3'(CR_OFF)) rdata = cr_byte;
      else                        rdata = snap_byte;
    end
  end

endmodule

// File: rtl/cia_timer_bank.sv
// Parametrised CIA-style timer bank: NTMR down-counters of TW bits behind an
// 8-bit register bus, with optional cascading of each channel from its
// predecessor and a shared ICR-style interrupt controller.
// Ports:
//   clk, reset_n, clk7_en  clock, sync active-low reset, state-advance enable
//   bus                    register bus (slave side)
//   eclk                   E-clock count enable
//   irq                    registered interrupt request, |(status & mask)
//   tmr_ovf                per-channel underflow pulse
// Map: channel i at 8*i (bytes 0..NB-1 counter LSB first, 4 = CR),
//      ICR at 8*NTMR, everything else reads 0.
module cia_timer_bank
  import cia_pkg::*;
#(
  parameter int NTMR = 4,
  parameter int TW   = 16,
  parameter int AW   = 6
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clk7_en,
  cia_timer_bank_if.slave bus,
  input  logic            eclk,
  output logic            irq,
  output logic [NTMR-1:0] tmr_ovf
);

  localparam int ICR_ADDR = icr_addr(NTMR);

  logic            rd_act;
  logic            wr_act;
  logic            icr_hit;
  logic            icr_rd;
  logic            icr_wr;
  logic [NTMR-1:0] status;
  logic [NTMR-1:0] mask;
  logic [7:0]      icr_byte;
  logic [7:0]      rdata_or;
  logic [7:0]      ch_rdata [NTMR];

  // Simultaneous rd and wr is treated as a write with no read data.
  assign wr_act  = bus.aen & bus.wr;
  assign rd_act  = bus.aen & bus.rd & ~bus.wr;
  assign icr_hit = (bus.rs == AW'(ICR_ADDR));
  assign icr_rd  = rd_act & icr_hit;
  assign icr_wr  = wr_act & icr_hit;

  for (genvar i = 0; i < NTMR; i++) begin : g_ch
    logic hit;
    logic cnt_in;
    logic inmode;
    logic ovf;

    assign hit = (bus.rs[AW-1:3] == (AW-3)'(i));

    // Channel 0 has no predecessor, so it always counts eclk. Later channels
    // take the predecessor's same-cycle underflow, letting a carry ripple
    // down the whole chain within one clk7_en cycle.
    if (i == 0) begin : g_src
      assign cnt_in = eclk;
    end else begin : g_src
      assign cnt_in = inmode ? g_ch[i-1].ovf : eclk;
    end

    cia_tmr_chan #(
      .TW(TW)
    ) u_chan (
      .clk    (clk),
      .reset_n(reset_n),
      .clk7_en(clk7_en),
      .cnt_in (cnt_in),
      .wsel   (wr_act & hit),
      .rsel   (rd_act & hit),
      .off    (bus.rs[2:0]),
      .data_in(bus.data_in),
      .rdata  (ch_rdata[i]),
      .inmode (inmode),
      .ovf    (ovf)
    );

    assign tmr_ovf[i] = ovf;
  end

  // A read-clear loses to an underflow arriving in the same cycle.
  // irq is taken from the registered status/mask, so it trails them by one.
  always_ff @(posedge clk) begin
    if (clk7_en) begin
      if (!reset_n) begin
        status <= '0;
        mask   <= '0;
        irq    <= 1'b0;
      end else begin
        status <= (icr_rd ? '0 : status) | tmr_ovf;
        if (icr_wr) begin
          if (bus.data_in[ICR_SETCLR]) mask <= mask | bus.data_in[NTMR-1:0];
          else                         mask <= mask & ~bus.data_in[NTMR-1:0];
        end
        irq <= |(status & mask);
      end
    end
  end

  always_comb begin
    icr_byte             = '0;
    icr_byte[NTMR-1:0]   = status;
    icr_byte[ICR_SETCLR] = irq;
  end

  // Unselected sources drive 0, so a plain OR forms the read mux.
  always_comb begin
    rdata_or = '0;
    for (int i = 0; i < NTMR; i++) rdata_or = rdata_or | ch_rdata[i];
    if (icr_rd) rdata_or = rdata_or | icr_byte;
  end

  assign bus.data_out = rdata_or;

endmodule

// File: doc/cia_timer_bank.md
Name: cia_timer_bank

Overview:
- Parametrised next-generation CIA timer/interrupt block: NTMR independent down-counters of TW bits behind one 8-bit CIA-style register bus, plus a shared ICR-style interrupt controller.
- Adds what the fixed two-timer CIA lacks: arbitrary channel count and width, cascading any timer from its predecessor, and tear-free multi-byte counter reads.
- Sits beside the CIAs on the chip-bus peripheral decode.
- Its data_out is OR-combined onto the CIA read bus.

Parameters:
- NTMR, 4, number of timer channels (1..7).
- TW, 16, counter width in bits (8, 16, 24 or 32); NB = TW/8 bytes per counter.
- AW, 6, register-select width; must satisfy 2^AW > 8*NTMR.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- clk7_en  in  1  7 MHz clock enable; all state advances only when high
- aen  in  1  address enable
- rd  in  1  read strobe
- wr  in  1  write strobe
- rs  in  AW  register select
- data_in  in  8  write data
- data_out  out  8  read data; 0 when not selected or not reading
- eclk  in  1  E-clock count enable, one clk7_en cycle wide
- irq  out  1  interrupt request, active high
- tmr_ovf  out  NTMR  per-channel underflow pulse, one clk7_en cycle

Behaviour:
- Clocking and reset: one clock; reset is synchronous, active-low (reset_n), sampled only when clk7_en is high.
- sel = aen & (rd | wr).
- Register map, channel i at base 8*i:
  - offsets 0..NB-1: counter bytes, LSB first.
  - offset 4: control register CR.
  - offsets NB..3 and 5..7 are reserved: they read 0 and ignore writes.
- ICR lives at address 8*NTMR. All other addresses read 0.
- CR bits:
  - 0 START: run.
  - 3 RUNMODE: 1 = one-shot.
  - 4 LOAD: strobe, always reads 0.
  - 5 INMODE: 0 = count eclk; 1 = count underflows of channel i-1. For channel 0, INMODE=1 counts eclk.
  - Other CR bits read 0.
- Reset values:
  - latch and counter all ones.
  - CR = 0.
  - ICR status and mask = 0.
  - read snapshot = 0.
  - irq = 0, tmr_ovf = 0.
- Counter byte write: updates the latch byte only. Writing the top byte (NB-1) also loads counter from latch when START=0. If RUNMODE=1, that write additionally sets START (load-and-go).
- LOAD=1 on a CR write: counter <= latch that cycle, and no decrement occurs that cycle.
- Count event: START & (INMODE ? ovf[i-1] : eclk).
- On a count event, when counter==0:
  - counter <= latch.
  - tmr_ovf[i]=1 for that cycle.
  - ICR status[i] set.
  - if RUNMODE=1, START cleared.
- On a count event otherwise: counter decrements by 1; no wrap below 0 without an underflow.
- Cascade is combinational within one clk7_en cycle. An underflow of channel i-1 counts channel i in the same cycle; the chain ripples through all channels.
- Tear-free reads:
  - Reading byte 0 returns the live low byte and snapshots counter[TW-1:8].
  - Reading bytes 1..NB-1 returns the snapshot.
  - When TW=8 there is no snapshot.
- ICR write:
  - data_in[7]=1: mask |= data_in[NTMR-1:0].
  - data_in[7]=0: mask &= ~data_in[NTMR-1:0].
- ICR read:
  - returns {irq, zeros, status[NTMR-1:0]}.
  - clears status on rd & clk7_en.
  - Read-clear and a new underflow in the same cycle: the new underflow's bit stays set.
- irq = |(status & mask), from registers. It updates the cycle after a status or mask change.
- Reset mid-count: all state returns to reset values; no underflow is reported for that cycle.
- rd and wr together: write wins, and data_out = 0.

Decomposition:
- Shared package cia_pkg holds:
  - register offsets (CNT0, CR=4, ICR base).
  - CR bit indices START, RUNMODE, LOAD, INMODE.
  - ICR SETCLR bit 7.
  - helper function for NB.
- Sub-module cia_tmr_chan, one instance per channel. It holds latch, counter, CR and snapshot, and takes cnt_in (eclk or predecessor ovf) and outputs ovf.
- The top level holds the generate loop, address decode, ICR and the data_out OR-mux.

Test Plan:
- Load and continuous count: NTMR=4, TW=16; write ch0 bytes 0x03,0x00; CR=0x01; eclk every cycle. Required: counter 3,2,1,0; underflow on the 4th event; reload to 3; tmr_ovf[0] pulses; status[0]=1.
- One-shot load-and-go: ch1 CR=0x08, then write top byte with latch=0x0002. Required: START=1 immediately; exactly one underflow after 3 events; START=0; counter holds 2.
- Cascade: ch0 latch=1 continuous; ch1 INMODE=1, latch=0x0001, started. Required: ch1 underflows on every 2nd ch0 underflow, in the same cycle as that ch0 underflow.
- Tear-free read: ch0 counter=0x0100, eclk running. Read byte0 (=0x00), wait until the live value is 0x00FE, read byte1. Required: byte1 returns 0x01.
- ICR: write 0x81 (mask bit0), force ch0 underflow. Required: irq=1 next cycle; ICR read = 0x81; status cleared; irq=0 next cycle. Underflow coinciding with the read leaves status[0]=1.
- Reset: assert reset_n=0 mid-count. Required: counters 0xFFFF, CR=0, irq=0, data_out=0.
